// File: rtl/cluster_tx_formatter.sv
// Packs eight 14-bit clusters per bunch crossing into a 4-word, parity-protected link frame through a 2-entry frame buffer.
// Build macro CLUSTER_EMPTY_SUPPRESS_EN: all-invalid cluster sets without bc0 are not sent.
module cluster_tx_formatter (
  input  logic        clock4x,
  input  logic        reset,
  input  logic [13:0] cluster0,
  input  logic [13:0] cluster1,
  input  logic [13:0] cluster2,
  input  logic [13:0] cluster3,
  input  logic [13:0] cluster4,
  input  logic [13:0] cluster5,
  input  logic [13:0] cluster6,
  input  logic [13:0] cluster7,
  input  logic        bx_strobe,
  input  logic        bc0,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic [11:0] bx_cnt,
  output logic [15:0] overflow_cnt
);
  localparam int unsigned SET_W = 113;
  localparam logic [11:0] BX_MAX = 12'd3563;

  // Stored set layout: {bc0, cluster7 .. cluster0}
  logic [SET_W-1:0] in_set;
  logic [SET_W-1:0] buf_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [1:0]       word_q, word_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [11:0]      bx_cnt_q;
  logic [15:0]      ovf_q;
  logic             consume, free, full, keep, accept, drop, load;
  logic [SET_W-1:0] src_set;
  logic [1:0]       src_word;

  assign in_set = {bc0, cluster7, cluster6, cluster5, cluster4,
                   cluster3, cluster2, cluster1, cluster0};

`ifdef CLUSTER_EMPTY_SUPPRESS_EN
  logic [7:0] clu_valid;
  always_comb begin
    clu_valid = '0;
    for (int i = 0; i < 8; i++) begin
      clu_valid[i] = (in_set[14*i +: 11] < 11'd1536);
    end
  end
  assign keep = bc0 || (|clu_valid);
`else
  assign keep = 1'b1;
`endif

  function automatic logic [31:0] fmt_word(input logic [SET_W-1:0] s, input logic [1:0] k);
    logic [27:0] pair;
    pair = s[28*int'(k) +: 28];
    return {k, (k == 2'd0) && s[SET_W-1], ^pair, pair};
  endfunction

  always_comb begin
    consume    = tx_valid_q && tx_ready;
    free       = consume && (word_q == 2'd3);
    full       = (count_q == 2'd2);
    accept     = bx_strobe && keep && (!full || free);
    drop       = bx_strobe && keep && full && !free;
    count_d    = count_q + {1'b0, accept} - {1'b0, free};
    word_d     = word_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    src_set    = buf_q[rd_ptr_q];
    src_word   = word_q + 2'd1;
    load       = 1'b0;
    // On the last word the next frame comes from the other entry, or straight from the input
    if (free) begin
      word_d   = 2'd0;
      src_word = 2'd0;
      if (full) begin
        src_set = buf_q[~rd_ptr_q];
        load    = 1'b1;
      end else if (accept) begin
        src_set = in_set;
        load    = 1'b1;
      end else begin
        tx_valid_d = 1'b0;
      end
    end else if (consume) begin
      word_d = word_q + 2'd1;
      load   = 1'b1;
    end else if (!tx_valid_q && accept) begin
      src_set  = in_set;
      src_word = 2'd0;
      load     = 1'b1;
    end
    if (load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = fmt_word(src_set, src_word);
    end
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      count_q    <= 2'd0;
      word_q     <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      bx_cnt_q   <= '0;
      ovf_q      <= '0;
    end else begin
      count_q    <= count_d;
      word_q     <= word_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (free)   rd_ptr_q <= ~rd_ptr_q;
      if (bx_strobe) begin
        bx_cnt_q <= (bc0 || bx_cnt_q == BX_MAX) ? 12'd0 : bx_cnt_q + 12'd1;
      end
      if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clock4x) begin
    if (accept && !reset) buf_q[wr_ptr_q] <= in_set;
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign bx_cnt       = bx_cnt_q;
  assign overflow_cnt = ovf_q;
endmodule

// File: tb/tb_cluster_tx_formatter.sv
// Directed bench for cluster_tx_formatter with a word scoreboard fed at strobe time and drained on each handshake.
module tb_cluster_tx_formatter;
  localparam int SEND = 0;
  localparam int DROP = 1;
  localparam int SUPP = 2;

  logic              clock4x = 1'b0;
  logic              reset, bx_strobe, bc0, tx_ready;
  logic [7:0][13:0]  cl;
  logic [31:0]       tx_data;
  logic              tx_valid;
  logic [11:0]       bx_cnt;
  logic [15:0]       overflow_cnt;

  int                checks = 0;
  int                errors = 0;
  logic [31:0]       sb [$];
  logic [11:0]       exp_bx = '0;
  logic [15:0]       exp_ovf = '0;
  logic [31:0]       exp_w;
  logic [31:0]       t1w [4];
  bit                prev_hold = 1'b0;
  logic [31:0]       prev_dat;

  always #5 clock4x = ~clock4x;

  cluster_tx_formatter dut (
    .clock4x(clock4x), .reset(reset),
    .cluster0(cl[0]), .cluster1(cl[1]), .cluster2(cl[2]), .cluster3(cl[3]),
    .cluster4(cl[4]), .cluster5(cl[5]), .cluster6(cl[6]), .cluster7(cl[7]),
    .bx_strobe(bx_strobe), .bc0(bc0), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .bx_cnt(bx_cnt), .overflow_cnt(overflow_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [13:0] lo, input logic [13:0] hi,
                                      input logic b0, input int k);
    logic [27:0] pl;
    logic        p;
    pl = {hi, lo};
    p  = 1'b0;
    for (int i = 0; i < 28; i++) p = p ^ pl[i];
    return {k[1:0], (k == 0) ? b0 : 1'b0, p, pl};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clock4x);
  endtask

  task automatic rand_set();
    for (int i = 0; i < 8; i++) cl[i] = 14'($urandom);
  endtask

  task automatic strobe(input logic b, input int mode);
    @(posedge clock4x); #1;
    bc0 = b;
    bx_strobe = 1'b1;
    if (mode == SEND) for (int k = 0; k < 4; k++) sb.push_back(fmt(cl[2*k], cl[2*k+1], b, k));
    if (mode == DROP && exp_ovf != 16'hFFFF) exp_ovf = exp_ovf + 16'd1;
    exp_bx = (b || exp_bx == 12'd3563) ? 12'd0 : exp_bx + 12'd1;
    @(posedge clock4x); #1;
    bx_strobe = 1'b0;
    bc0 = 1'b0;
  endtask

  always @(negedge clock4x) begin
    if (prev_hold) begin
      chk("hold_vld", {31'd0, tx_valid}, 32'd1);
      chk("hold_dat", tx_data, prev_dat);
    end
    if (!reset && tx_valid && tx_ready) begin
      exp_w = (sb.size() > 0) ? sb.pop_front() : ~tx_data;
      chk("word", tx_data, exp_w);
    end
    prev_hold = !reset && tx_valid && !tx_ready;
    prev_dat  = tx_data;
  end

  initial begin
    reset = 1'b1; bx_strobe = 1'b0; bc0 = 1'b0; tx_ready = 1'b1; cl = '0;
    @(posedge clock4x); #1 bx_strobe = 1'b1;
    @(posedge clock4x); #1 bx_strobe = 1'b0;
    @(posedge clock4x); #1 reset = 1'b0;
    @(negedge clock4x);
    chk("rst_vld", {31'd0, tx_valid}, 32'd0);
    chk("rst_dat", tx_data, 32'd0);
    chk("rst_bx", {20'd0, bx_cnt}, 32'd0);
    chk("rst_ovf", {16'd0, overflow_cnt}, 32'd0);

    // Single frame, fixed pattern, exact latency and length
    for (int i = 0; i < 8; i++) cl[i] = 14'h07FE;
    cl[0] = 14'h0805;
    t1w[0] = 32'h11FF8805; t1w[1] = 32'h41FF87FE; t1w[2] = 32'h81FF87FE; t1w[3] = 32'hC1FF87FE;
    strobe(1'b0, SEND);
    for (int j = 0; j < 4; j++) begin
      @(negedge clock4x);
      chk("t1_vld", {31'd0, tx_valid}, 32'd1);
      chk("t1_word", tx_data, t1w[j]);
    end
    @(negedge clock4x);
    chk("t1_end_vld", {31'd0, tx_valid}, 32'd0);
    chk("t1_idle_dat", tx_data, t1w[3]);
    chk("t1_bx", {20'd0, bx_cnt}, {20'd0, exp_bx});

    // bx counter: 100 strobes, bc0 reload, then full wrap
    for (int s = 0; s < 100; s++) begin
      rand_set();
      strobe(1'b0, SEND);
      idle(2);
    end
    chk("bx_100", {20'd0, bx_cnt}, {20'd0, exp_bx});
    rand_set();
    strobe(1'b1, SEND);
    @(negedge clock4x);
    chk("bc0_bx", {20'd0, bx_cnt}, 32'd0);
    chk("bc0_flag", {31'd0, tx_data[29]}, 32'd1);
    idle(2);
    for (int s = 0; s < 3563; s++) begin
      strobe(1'b0, SEND);
      idle(2);
    end
    chk("bx_max", {20'd0, bx_cnt}, 32'd3563);
    strobe(1'b0, SEND);
    @(negedge clock4x);
    chk("bx_wrap", {20'd0, bx_cnt}, 32'd0);
    idle(8);
    chk("drain1", sb.size(), 32'd0);

    // Stall: two frames buffered, third dropped, then 8 contiguous words
    @(posedge clock4x); #1 tx_ready = 1'b0;
    rand_set();
    t1w[0] = fmt(cl[0], cl[1], 1'b0, 0);
    strobe(1'b0, SEND); idle(2);
    rand_set();
    strobe(1'b0, SEND); idle(2);
    rand_set();
    strobe(1'b0, DROP); idle(2);
    @(negedge clock4x);
    chk("ovf_1", {16'd0, overflow_cnt}, {16'd0, exp_ovf});
    chk("stall_vld", {31'd0, tx_valid}, 32'd1);
    chk("stall_dat", tx_data, t1w[0]);
    chk("drop_bx", {20'd0, bx_cnt}, {20'd0, exp_bx});
    @(posedge clock4x); #1 tx_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock4x);
      chk("contig_vld", {31'd0, tx_valid}, 32'd1);
    end
    @(negedge clock4x);
    chk("contig_end", {31'd0, tx_valid}, 32'd0);
    chk("drain2", sb.size(), 32'd0);

    // Full buffer, strobe lands on the cycle the head's last word leaves
    @(posedge clock4x); #1 tx_ready = 1'b0;
    rand_set(); strobe(1'b0, SEND); idle(2);
    rand_set(); strobe(1'b0, SEND); idle(2);
    @(posedge clock4x); #1 tx_ready = 1'b1;
    idle(2);
    rand_set();
    strobe(1'b0, SEND);
    @(negedge clock4x);
    chk("same_cyc_ovf", {16'd0, overflow_cnt}, {16'd0, exp_ovf});
    idle(12);
    chk("drain3", sb.size(), 32'd0);
    chk("drain3_vld", {31'd0, tx_valid}, 32'd0);

    // Reset mid-frame after word 1
    rand_set();
    strobe(1'b0, SEND);
    @(posedge clock4x); #1;
    reset = 1'b1; tx_ready = 1'b0;
    sb.delete();
    exp_bx = '0; exp_ovf = '0;
    @(posedge clock4x); #1 reset = 1'b0;
    @(negedge clock4x);
    chk("mid_rst_vld", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_dat", tx_data, 32'd0);
    chk("mid_rst_bx", {20'd0, bx_cnt}, 32'd0);
    chk("mid_rst_ovf", {16'd0, overflow_cnt}, 32'd0);
    tx_ready = 1'b1;
    rand_set();
    t1w[0] = fmt(cl[0], cl[1], 1'b0, 0);
    strobe(1'b0, SEND);
    @(negedge clock4x);
    chk("fresh_vld", {31'd0, tx_valid}, 32'd1);
    chk("fresh_w0", tx_data, t1w[0]);
    chk("fresh_bx", {20'd0, bx_cnt}, 32'd1);
    idle(6);

    // Address boundary: 1535 is the highest valid address, so this set is always sent
    for (int i = 0; i < 8; i++) cl[i] = {3'(i), 11'h600 + 11'(i)};
    cl[3] = {3'd1, 11'h5FF};
    strobe(1'b0, SEND);
    @(negedge clock4x);
    chk("edge_addr_vld", {31'd0, tx_valid}, 32'd1);
    idle(6);

    // All-invalid set
    for (int i = 0; i < 8; i++) cl[i] = {3'(i), 11'h7FF - 11'(i)};
`ifdef CLUSTER_EMPTY_SUPPRESS_EN
    strobe(1'b0, SUPP);
    for (int j = 0; j < 4; j++) begin
      @(negedge clock4x);
      chk("supp_vld", {31'd0, tx_valid}, 32'd0);
    end
    chk("supp_bx", {20'd0, bx_cnt}, {20'd0, exp_bx});
    strobe(1'b1, SEND);
    @(negedge clock4x);
    chk("supp_bc0_vld", {31'd0, tx_valid}, 32'd1);
`else
    strobe(1'b0, SEND);
    @(negedge clock4x);
    chk("invalid_sent_vld", {31'd0, tx_valid}, 32'd1);
    chk("invalid_bx", {20'd0, bx_cnt}, {20'd0, exp_bx});
`endif
    idle(8);
    chk("final_drain", sb.size(), 32'd0);
    chk("final_ovf", {16'd0, overflow_cnt}, {16'd0, exp_ovf});
    chk("final_bx", {20'd0, bx_cnt}, {20'd0, exp_bx});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
